attn_out_streamer: RTL and testbench

//  Output-side reader for the self-attention top. Captures the flat output token matrix when the
//  top's sticky done rises, then serialises it one token vector per beat over valid/ready.

---
 rtl/attn_pkg.sv | 13 +
 rtl/attn_out_streamer_rise_detect.sv | 19 +
 rtl/attn_out_streamer.sv | 100 ++++++++++
 tb/tb_attn_out_streamer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// Shared types and default geometry for the attention output path.
package attn_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int SEQ_LEN_DEF    = 64;
    localparam int EMBED_DIM_DEF  = 64;

    localparam int TOKEN_W = DATA_WIDTH_DEF * EMBED_DIM_DEF;
    localparam int IDX_W   = $clog2(SEQ_LEN_DEF);

    typedef enum logic [0:0] {S_IDLE, S_STREAM} stream_state_t;

endpackage

// File: rtl/attn_out_streamer_rise_detect.sv
// Rising-edge detector for level/sticky done signals; a level already high
// when reset is released counts as one rise.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/attn_out_streamer.sv
// Captures the attention output matrix on done and streams it one token per
// beat. Handshake: a beat transfers on a clock edge where out_valid & out_ready;
// once raised, out_valid and the beat contents hold until that transfer.
module attn_out_streamer
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SEQ_LEN    = SEQ_LEN_DEF,
    parameter int EMBED_DIM  = EMBED_DIM_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   attn_done,
    input  logic [DATA_WIDTH*SEQ_LEN*EMBED_DIM-1:0] tokens_flat,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH*EMBED_DIM-1:0]        out_data,
    output logic [$clog2(SEQ_LEN)-1:0]             out_token_idx,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   overrun,
    output logic [15:0]                            frames_sent
);

    localparam int TW     = DATA_WIDTH * EMBED_DIM;
    localparam int IW     = $clog2(SEQ_LEN);
    localparam int FLAT_W = TW * SEQ_LEN;
    localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);

    stream_state_t     state;
    logic [FLAT_W-1:0] buffer;
    logic              done_rise;
    logic              handshake;
    logic              capture;

    rise_detect u_rise (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (attn_done),
        .rise (done_rise)
    );

    assign handshake = out_valid & out_ready;
    assign capture   = (state == S_IDLE) & done_rise;

    // Frame storage survives reset; only a fresh capture overwrites it.
    always_ff @(posedge clk) begin
        if (capture) buffer <= tokens_flat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            out_token_idx <= '0;
            frames_sent   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (done_rise) begin
                        out_token_idx <= '0;
                        out_valid     <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // A rise while streaming is recorded and discarded, never queued.
                    if (done_rise) overrun <= 1'b1;
                    if (handshake) begin
                        if (out_token_idx == LAST_IDX) begin
                            out_token_idx <= '0;
                            out_valid     <= 1'b0;
                            busy          <= 1'b0;
                            frames_sent   <= frames_sent + 16'd1;
                            state         <= S_IDLE;
                        end else begin
                            out_token_idx <= out_token_idx + IW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int t = 0; t < SEQ_LEN; t++) begin
                if (out_token_idx == IW'(t)) out_data = buffer[t*TW +: TW];
            end
        end
    end

    assign out_last = out_valid & (out_token_idx == LAST_IDX);

endmodule

// File: tb/tb_attn_out_streamer.sv
// Scoreboard bench for attn_out_streamer with a small 4-token, 2-element frame.
module tb_attn_out_streamer;

    localparam int DW = 16;
    localparam int SL = 4;
    localparam int ED = 2;
    localparam int TW = DW * ED;
    localparam int IW = $clog2(SL);
    localparam int FW = TW * SL;
    localparam int BW = 1 + IW + TW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          attn_done = 1'b0;
    logic [FW-1:0] tokens_flat = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [TW-1:0] out_data;
    logic [IW-1:0] out_token_idx;
    logic          out_last;
    logic          busy;
    logic          overrun;
    logic [15:0]   frames_sent;

    attn_out_streamer #(
        .DATA_WIDTH(DW),
        .SEQ_LEN   (SL),
        .EMBED_DIM (ED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .attn_done    (attn_done),
        .tokens_flat  (tokens_flat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_token_idx(out_token_idx),
        .out_last     (out_last),
        .busy         (busy),
        .overrun      (overrun),
        .frames_sent  (frames_sent)
    );

    // clock / reset
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [BW-1:0] exp_q[$];
    logic [15:0]   exp_frames = '0;
    logic          ready_rand = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] pattern_flat();
        logic [FW-1:0] f;
        f = '0;
        for (int t = 0; t < SL; t++) begin
            f[t*TW +: TW] = {16'(t*2+1), 16'(t*2)};
        end
        return f;
    endfunction

    function automatic logic [FW-1:0] random_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < SL*ED; i++) f[i*DW +: DW] = 16'($urandom_range(0, 16'hFFFF));
        return f;
    endfunction

    task automatic push_frame(input logic [FW-1:0] f);
        for (int t = 0; t < SL; t++) begin
            exp_q.push_back({(t == SL-1), IW'(t), f[t*TW +: TW]});
        end
    endtask

    task automatic drop_done();
        attn_done = 1'b0;
        step();
    endtask

    // Raise done with new data; the capture happens on the next edge.
    task automatic launch(input logic [FW-1:0] f);
        tokens_flat = f;
        attn_done   = 1'b1;
        push_frame(f);
        step();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_valid_low"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_frames"}, 64'(frames_sent), 64'(exp_frames));
    endtask

    task automatic wait_idx(input int idx, input string tag);
        int n;
        n = 0;
        while (!(out_valid && out_token_idx == IW'(idx)) && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, 64'(out_token_idx), 64'(idx));
    endtask

    // random ready driver
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // scoreboard: a beat seen valid&ready at negedge transfers on the next edge
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat;
    initial forever begin
        logic [BW-1:0] exp_beat;
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(out_valid), 64'd1);
                check_eq("stall_beat", 64'({out_last, out_token_idx, out_data}), 64'(prev_beat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat_idx", 64'(out_token_idx), 64'hDEAD);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check_eq("beat", 64'({out_last, out_token_idx, out_data}), 64'(exp_beat));
                    if (exp_beat[BW-1]) exp_frames = exp_frames + 16'd1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_token_idx, out_data};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] f;

        // reset state
        rst_n = 1'b0;
        repeat (3) step();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_last", 64'(out_last), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        check_eq("rst_idx", 64'(out_token_idx), 64'd0);
        check_eq("rst_frames", 64'(frames_sent), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: basic frame, ready high, one beat per clock
        out_ready = 1'b1;
        f = pattern_flat();
        tokens_flat = f;
        attn_done = 1'b1;
        push_frame(f);
        check_eq("t1_no_early_valid", 64'(out_valid), 64'd0);
        step();
        check_eq("t1_busy", 64'(busy), 64'd1);
        for (int k = 0; k < SL; k++) begin
            check_eq("t1_valid", 64'(out_valid), 64'd1);
            check_eq("t1_idx", 64'(out_token_idx), 64'(k));
            check_eq("t1_last", 64'(out_last), 64'(k == SL-1));
            step();
        end
        check_eq("t1_valid_after", 64'(out_valid), 64'd0);
        check_eq("t1_frames", 64'(frames_sent), 64'd1);
        drain("t1");

        // 2: backpressure, stall on idx 1 then random ready
        drop_done();
        out_ready = 1'b0;
        launch(random_flat());
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (5) step();
        check_eq("t2_stall_idx", 64'(out_token_idx), 64'd1);
        check_eq("t2_stall_valid", 64'(out_valid), 64'd1);
        ready_rand = 1'b1;
        drain("t2");

        // 3: overrun, done re-pulsed during idx 2
        drop_done();
        launch(random_flat());
        wait_idx(2, "t3_reach_idx2");
        attn_done = 1'b0;
        tokens_flat = random_flat();
        step();
        attn_done = 1'b1;
        step();
        drain("t3");
        check_eq("t3_overrun", 64'(overrun), 64'd1);
        repeat (10) step();
        check_eq("t3_no_second_frame", 64'(out_valid), 64'd0);
        check_eq("t3_frames_hold", 64'(frames_sent), 64'(exp_frames));

        // 4: done held high gives one frame; next rise carries new data
        ready_rand = 1'b0;
        out_ready = 1'b1;
        drop_done();
        launch(random_flat());
        drain("t4a");
        repeat (20) step();
        check_eq("t4_held_valid", 64'(out_valid), 64'd0);
        check_eq("t4_held_frames", 64'(frames_sent), 64'd4);
        drop_done();
        launch(random_flat());
        drain("t4b");
        check_eq("t4_overrun_sticky", 64'(overrun), 64'd1);

        // 5: reset mid-frame, done still high recaptures after release
        drop_done();
        launch(random_flat());
        wait_idx(1, "t5_reach_idx1");
        rst_n = 1'b0;
        f = random_flat();
        tokens_flat = f;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        exp_frames = '0;
        check_eq("t5_valid", 64'(out_valid), 64'd0);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_frames", 64'(frames_sent), 64'd0);
        check_eq("t5_overrun", 64'(overrun), 64'd0);
        push_frame(f);
        step();
        check_eq("t5_restart_valid", 64'(out_valid), 64'd1);
        check_eq("t5_restart_idx", 64'(out_token_idx), 64'd0);
        drain("t5");

        // 6: frame counter wraps
        drop_done();
        force dut.frames_sent = 16'hFFFF;
        step();
        release dut.frames_sent;
        exp_frames = 16'hFFFF;
        check_eq("t6_preload", 64'(frames_sent), 64'hFFFF);
        launch(random_flat());
        drain("t6");
        check_eq("t6_wrapped", 64'(frames_sent), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
